// File: rtl/spectrum_bar_display_pkg.sv
// Shared types and default geometry for the spectrum bar renderer.
// Defaults describe the 640x480 @ 800x525 raster with 16 bars.
package spectrum_disp_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_COLOR_W   = 4;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HEIGHT_W = $clog2(DEF_V_DISPLAY + 1);

  typedef enum logic {IDLE, SCALE} scale_state_e;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int span_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/spectrum_bar_display_timing.sv
// Raster counters for the spectrum display: h/v position, raw active-low
// syncs, visible flag, vblank-start and frame-origin events.
module vga_timing
  import spectrum_disp_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int LINE_LEN    = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
  localparam int FRAME_LINES = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK),
  localparam int H_W = $clog2(LINE_LEN),
  localparam int V_W = $clog2(FRAME_LINES)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hsync_raw,
  output logic           vsync_raw,
  output logic           visible,
  output logic           vblank_start,
  output logic           frame_first
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_W'(LINE_LEN - 1)) begin
      h <= '0;
      v <= (v == V_W'(FRAME_LINES - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign hsync_raw = !((h >= H_W'(H_DISPLAY + H_FRONT)) &&
                       (h <  H_W'(H_DISPLAY + H_FRONT + H_SYNC)));
  assign vsync_raw = !((v >= V_W'(V_DISPLAY + V_FRONT)) &&
                       (v <  V_W'(V_DISPLAY + V_FRONT + V_SYNC)));

  assign visible      = (h < H_W'(H_DISPLAY)) && (v < V_W'(V_DISPLAY));
  assign vblank_start = (h == '0) && (v == V_W'(V_DISPLAY));
  assign frame_first  = (h == '0) && (v == '0);

endmodule

// File: rtl/spectrum_bar_display.sv
// VGA spectrum renderer: captures bins, scales them to bar heights during
// vblank and draws bars through a 2-stage pixel pipeline. Optional PEAK_HOLD_EN.
//
// state | meaning
// IDLE  | waiting for vblank start
// SCALE | one bin per cycle: clamp, multiply, store height (and peak)
module spectrum_bar_display
  import spectrum_disp_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int NUM_BARS   = 16,
  parameter int BIN_W      = 16,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int BAR_GAP    = 2,
  parameter logic [3*DEF_COLOR_W-1:0] BAR_RGB = 12'hC00,
  parameter int PEAK_DECAY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bins_valid,
  input  logic [NUM_BARS*BIN_W-1:0] bins_data,
  output logic                      hsync,
  output logic                      vsync,
  output logic [COLOR_W-1:0]        r,
  output logic [COLOR_W-1:0]        g,
  output logic [COLOR_W-1:0]        b,
  output logic                      frame_start
);

  localparam int LINE_LEN    = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int FRAME_LINES = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int H_W    = $clog2(LINE_LEN);
  localparam int V_W    = $clog2(FRAME_LINES);
  localparam int BAR_W  = H_DISPLAY / NUM_BARS;
  localparam int COL_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int IDX_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int HT_W   = $clog2(V_DISPLAY + 1);
  localparam int PROD_W = BIN_W + HT_W;
  localparam rgb_t BAR_C = rgb_t'(BAR_RGB);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           hsync_raw, vsync_raw, visible, vblank_start, frame_first;

  vga_timing #(
    .H_DISPLAY (H_DISPLAY), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_DISPLAY (V_DISPLAY), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .h            (h),
    .v            (v),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .visible      (visible),
    .vblank_start (vblank_start),
    .frame_first  (frame_first)
  );

  // Column/bar tracking follows h without a divider; holds on the last bar past the display area.
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] bar;
  logic             gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      bar <= '0;
    end else if (h == H_W'(LINE_LEN - 1)) begin
      col <= '0;
      bar <= '0;
    end else if (h < H_W'(H_DISPLAY - 1)) begin
      if (col == COL_W'(BAR_W - 1)) begin
        col <= '0;
        bar <= bar + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign gap = (BAR_GAP != 0) && (col >= COL_W'(BAR_W - BAR_GAP));

  // Pending bank takes every strobe; the work bank is frozen at vblank start for the scaler.
  logic [NUM_BARS*BIN_W-1:0] pend_bank, work_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bank <= '0;
      work_bank <= '0;
    end else begin
      if (bins_valid)   pend_bank <= bins_data;
      if (vblank_start) work_bank <= pend_bank;
    end
  end

  scale_state_e     state, state_nx;
  logic [IDX_W-1:0] idx;
  logic             scale_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vblank_start) state_nx = SCALE;
      SCALE:   if (idx == IDX_W'(NUM_BARS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    scale_en = (state == SCALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             idx <= '0;
    else if (state == IDLE) idx <= '0;
    else                    idx <= idx + 1'b1;
  end

  logic [BIN_W-1:0]  bin_sel;
  logic [BIN_W-2:0]  mag;
  logic [PROD_W-1:0] prod;
  logic [HT_W-1:0]   new_h;

  assign bin_sel = work_bank[int'(idx)*BIN_W +: BIN_W];
  assign mag     = bin_sel[BIN_W-1] ? '0 : bin_sel[BIN_W-2:0];
  assign prod    = PROD_W'(mag) * PROD_W'(V_DISPLAY);
  assign new_h   = HT_W'(prod >> (BIN_W - 1));

  logic [HT_W-1:0] height [NUM_BARS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BARS; i++) height[i] <= '0;
    end else if (scale_en) begin
      height[idx] <= new_h;
    end
  end

  logic [V_W-1:0]   s1_v;
  logic [IDX_W-1:0] s1_bar;
  logic             s1_gap, s1_vis, s1_hs, s1_vs, s1_fs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= '0;
      s1_bar <= '0;
      s1_gap <= 1'b0;
      s1_vis <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_fs  <= 1'b0;
    end else begin
      s1_v   <= v;
      s1_bar <= bar;
      s1_gap <= gap;
      s1_vis <= visible;
      s1_hs  <= hsync_raw;
      s1_vs  <= vsync_raw;
      s1_fs  <= frame_first;
    end
  end

  logic bar_on, peak_on;
  assign bar_on = s1_vis && !s1_gap &&
                  (s1_v >= V_W'(V_DISPLAY) - V_W'(height[s1_bar]));

`ifdef PEAK_HOLD_EN
  logic [HT_W-1:0] peak [NUM_BARS];
  logic [HT_W-1:0] peak_dec;
  logic [V_W-1:0]  peak_top;

  assign peak_dec = (peak[idx] > HT_W'(PEAK_DECAY)) ? peak[idx] - HT_W'(PEAK_DECAY) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BARS; i++) peak[i] <= '0;
    end else if (scale_en) begin
      peak[idx] <= (new_h > peak_dec) ? new_h : peak_dec;
    end
  end

  // A zero peak places the marker rows below the visible area, so it is never drawn.
  assign peak_top = V_W'(V_DISPLAY) - V_W'(peak[s1_bar]);
  assign peak_on  = s1_vis && !s1_gap && (s1_v >= peak_top) && (s1_v <= peak_top + 1'b1);
`else
  assign peak_on = 1'b0;
`endif

  rgb_t pix, pix_nx;

  always_comb begin
    pix_nx = '0;
    if (peak_on)     pix_nx = '1;
    else if (bar_on) pix_nx = BAR_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix         <= pix_nx;
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      frame_start <= s1_fs;
    end
  end

  assign r = COLOR_W'(pix.r);
  assign g = COLOR_W'(pix.g);
  assign b = COLOR_W'(pix.b);

endmodule

// File: tb/tb_spectrum_bar_display.sv
// Randomized bench for spectrum_bar_display on a reduced raster, checked per
// pixel against a frame-level model of capture, scaling and drawing.
module tb_spectrum_bar_display;

  localparam int HD = 64, HF = 4, HS = 8, HB = 4;
  localparam int VD = 48, VF = 2, VS = 2, VB = 4;
  localparam int NB = 8, BW = 16, GAP = 2, DECAY = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BARW = HD / NB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bins_valid = 1'b0;
  logic [NB*BW-1:0]  bins_data = '0;
  logic              hsync, vsync, frame_start;
  logic [3:0]        r, g, b;

  always #5 clk = ~clk;

  spectrum_bar_display #(
    .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .NUM_BARS (NB), .BIN_W (BW), .COLOR_W (4), .BAR_GAP (GAP),
    .BAR_RGB (12'hC00), .PEAK_DECAY (DECAY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bins_valid  (bins_valid),
    .bins_data   (bins_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .r           (r),
    .g           (g),
    .b           (b),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;
  int pos;
  int pend [NB];
  int hgt  [NB];
  int pk   [NB];
  int hs_low, vs_low, fs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int scale(input int raw);
    if (raw >= 32768) return 0;
    return (raw * VD) / 32768;
  endfunction

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < NB; i++) begin
      pend[i] = 0;
      hgt[i]  = 0;
      pk[i]   = 0;
    end
  endtask

  // Expected {hsync, vsync, frame_start, rgb} for raster position q (negative = before first pixel).
  function automatic logic [14:0] expect_px(input int q);
    int p, h, v, bar, col;
    logic hs, vs, fs;
    logic [11:0] c;
    p  = ((q % FT) + FT) % FT;
    h  = p % HT;
    v  = (p / HT) % VT;
    hs = !(h >= HD + HF && h < HD + HF + HS);
    vs = !(v >= VD + VF && v < VD + VF + VS);
    fs = (h == 0) && (v == 0);
    c  = 12'h000;
    if (h < HD && v < VD) begin
      bar = h / BARW;
      col = h % BARW;
      if (col < BARW - GAP) begin
        if (v >= VD - hgt[bar]) c = 12'hC00;
`ifdef PEAK_HOLD_EN
        if (pk[bar] > 0 && v >= VD - pk[bar] && v <= VD - pk[bar] + 1) c = 12'hFFF;
`endif
      end
    end
    return {hs, vs, fs, c};
  endfunction

  function automatic logic [NB*BW-1:0] rand_bins();
    logic [NB*BW-1:0] d;
    d = '0;
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 7))
        0:       d[i*BW +: BW] = 16'h7FFF;
        1:       d[i*BW +: BW] = 16'h8000;
        2:       d[i*BW +: BW] = 16'h0000;
        default: d[i*BW +: BW] = 16'($urandom());
      endcase
    end
    return d;
  endfunction

  function automatic logic [NB*BW-1:0] fill_bins(input logic [15:0] val);
    logic [NB*BW-1:0] d;
    for (int i = 0; i < NB; i++) d[i*BW +: BW] = val;
    return d;
  endfunction

  // Called at a negedge; drives inputs, advances one clock, checks the output pixel.
  task automatic run_cycle(input bit valid, input logic [NB*BW-1:0] data);
    logic [14:0] exp;
    int nh, dec;
    bins_valid = valid;
    bins_data  = data;
    @(posedge clk);
    if (pos % FT == VD * HT) begin
      for (int i = 0; i < NB; i++) begin
        nh  = scale(pend[i]);
        dec = (pk[i] > DECAY) ? pk[i] - DECAY : 0;
        pk[i]  = (nh > dec) ? nh : dec;
        hgt[i] = nh;
      end
    end
    if (valid)
      for (int i = 0; i < NB; i++) pend[i] = int'(data[i*BW +: BW]);
    pos++;
    @(negedge clk);
    bins_valid = 1'b0;
    exp = expect_px(pos - 2);
    chk($sformatf("pixel pos %0d", pos - 2), {17'b0, hsync, vsync, frame_start, r, g, b}, {17'b0, exp});
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic run_frames(input int n, input int rate, input bit directed);
    bit pv;
    logic [NB*BW-1:0] d;
    for (int c = 0; c < n * FT; c++) begin
      pv = 1'b0;
      d  = '0;
      if (rate > 0 && $urandom_range(0, rate - 1) == 0) pv = 1'b1;
      if (directed && ((pos % FT) == VD * HT + 3 || (pos % FT) == 10 * HT + 20)) pv = 1'b1;
      if (pv) d = rand_bins();
      run_cycle(pv, d);
    end
  endtask

  logic [NB*BW-1:0] pat;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset hsync", hsync, 1);
    chk("reset vsync", vsync, 1);
    chk("reset rgb", {r, g, b}, 0);
    chk("reset frame_start", frame_start, 0);
    rst_n = 1'b1;

    hs_low = 0; vs_low = 0; fs_cnt = 0;
    run_frames(1, 0, 0);
    chk("hsync low clocks per frame", hs_low, HS * VT);
    chk("vsync low clocks per frame", vs_low, VS * HT);
    chk("frame_start pulses per frame", fs_cnt, 1);

    run_cycle(1'b1, fill_bins(16'h7FFF));
    run_frames(2, 0, 0);

    for (int i = 0; i < FT && (pos % FT) != 20 * HT + 30; i++) run_cycle(1'b0, '0);
    chk("reset point reached", pos % FT, 20 * HT + 30);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset hsync", hsync, 1);
    chk("async reset vsync", vsync, 1);
    chk("async reset rgb", {r, g, b}, 0);
    chk("async reset frame_start", frame_start, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    run_frames(1, 0, 0);
    chk("frame_start after reset", fs_cnt, 1);

    pat = fill_bins(16'h4000);
    pat[3*BW +: BW] = 16'h8000;
    pat[4*BW +: BW] = 16'h0000;
    run_cycle(1'b1, pat);
    run_frames(2, 0, 0);

    run_frames(2, 900, 1);

    pat = rand_bins();
    pat[0 +: BW] = 16'h7FFF;
    run_cycle(1'b1, pat);
    run_frames(1, 0, 0);
    pat[0 +: BW] = 16'h0000;
    run_cycle(1'b1, pat);
    run_frames(3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
